// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: 2-flop input synchronizers, startup suppression, step/dir/count
// and a sticky illegal-transition flag. Define QDEC_FILTER_EN to add the input stability filter.
module quad_decoder #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  input  logic             ph_a,
  input  logic             ph_b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  typedef enum logic [1:0] {
    MV_NONE,
    MV_UP,
    MV_DOWN,
    MV_ILLEGAL
  } move_t;

  logic [1:0] a_sync;
  logic [1:0] b_sync;
  logic [1:0] sync_ab;
  logic [1:0] prev;
  logic [1:0] cur;
  logic [1:0] sup_cnt;
  move_t      move;

  assign sync_ab = {a_sync[1], b_sync[1]};

`ifdef QDEC_FILTER_EN
  localparam int unsigned SW = $clog2(FILT_LEN + 1);

  logic [1:0]    cand;
  logic [SW-1:0] stab_cnt;
  logic          stable;

  assign stable = (stab_cnt == SW'(FILT_LEN));

  // Until the candidate has been stable long enough, present prev so nothing is decoded.
  always_comb begin
    cur = stable ? cand : prev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand     <= '0;
      stab_cnt <= '0;
    end else if (sup_cnt != '0) begin
      cand     <= sync_ab;
      stab_cnt <= SW'(FILT_LEN);
    end else if (sync_ab == cand) begin
      if (!stable) stab_cnt <= stab_cnt + 1'b1;
    end else begin
      cand     <= sync_ab;
      stab_cnt <= SW'(1);
    end
  end
`else
  always_comb begin
    cur = sync_ab;
  end
`endif

  always_comb begin
    move = MV_NONE;
    case ({prev, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: move = MV_UP;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: move = MV_DOWN;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: move = MV_ILLEGAL;
      default:                                move = MV_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sync  <= '0;
      b_sync  <= '0;
      prev    <= '0;
      sup_cnt <= 2'd3;
      count   <= '0;
      dir     <= 1'b0;
      step    <= 1'b0;
      err     <= 1'b0;
    end else begin
      a_sync <= {a_sync[0], ph_a};
      b_sync <= {b_sync[0], ph_b};
      step   <= 1'b0;
      if (sup_cnt != '0) begin
        // Synchronizers still filling: follow them so static levels never decode as motion.
        sup_cnt <= sup_cnt - 1'b1;
        prev    <= sync_ab;
      end else begin
        prev <= cur;
        if (!preset) begin
          if (move == MV_UP) begin
            count <= count + 1'b1;
            dir   <= 1'b1;
            step  <= 1'b1;
          end else if (move == MV_DOWN) begin
            count <= count - 1'b1;
            dir   <= 1'b0;
            step  <= 1'b1;
          end
        end
      end
      if (preset) count <= '1;
      if ((sup_cnt == '0) && (move == MV_ILLEGAL)) err <= 1'b1;
      else if (err_clr)                            err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: sample-history reference model checked every cycle, plus
// directed scenarios with literal expectations and a randomized walk.
module tb_quad_decoder;
  localparam int W = 5;
  localparam int F = 3;
`ifdef QDEC_FILTER_EN
  localparam int LAT = 3 + F;
`else
  localparam int LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         preset = 1'b0;
  logic         ph_a = 1'b0;
  logic         ph_b = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] count;
  logic         dir;
  logic         step;
  logic         err;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  quad_decoder #(.WIDTH(W), .FILT_LEN(F)) dut (
    .clk(clk), .reset(reset), .preset(preset), .ph_a(ph_a), .ph_b(ph_b),
    .err_clr(err_clr), .count(count), .dir(dir), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pin samples per clock edge since reset release, decoded by position.
  logic [1:0] hist [16];
  int         n = 0;
  int         d;
  int         m_count = 0;
  bit         m_dir = 0;
  bit         m_step = 0;
  bit         m_err = 0;
  logic [1:0] m_prev = 2'b00;
  logic [1:0] m_cur;

  function automatic int pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] smp(input int j);
    int k = (j < 1) ? 1 : j;
    return hist[k % 16];
  endfunction

  function automatic logic [1:0] accepted(input int e);
`ifdef QDEC_FILTER_EN
    for (int j = e - 2 - F; j <= e - 3; j++)
      if (smp(j) != smp(e - 3)) return m_prev;
    return smp(e - 3);
`else
    return smp(e - 2);
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count = 0; m_dir = 0; m_step = 0; m_err = 0; m_prev = 2'b00; n = 0;
    end else begin
      n++;
      hist[n % 16] = {ph_a, ph_b};
      m_step = 0;
      d = 0;
      if (n <= 3) begin
        m_prev = (n == 3) ? smp(1) : 2'b00;
      end else begin
        m_cur  = accepted(n);
        d      = (pos(m_cur) - pos(m_prev)) & 3;
        m_prev = m_cur;
      end
      if (preset) m_count = (1 << W) - 1;
      else if (d == 1) begin
        m_count = (m_count + 1) % (1 << W); m_dir = 1; m_step = 1;
      end else if (d == 3) begin
        m_count = (m_count + (1 << W) - 1) % (1 << W); m_dir = 0; m_step = 1;
      end
      if (d == 2) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  always @(negedge clk) begin
    chk("model_count", count, m_count);
    chk("model_dir", dir, m_dir);
    chk("model_step", step, m_step);
    chk("model_err", err, m_err);
    if (step) pulses++;
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic reset_dut(input logic a, input logic b);
    ph_a = a; ph_b = b; preset = 0; err_clr = 0;
    reset = 1;
    tick(2);
    reset = 0;
    tick(6);
  endtask

  // Drive a new pin state and check latency, pulse width, count and dir of the result.
  task automatic move_to(input logic a, input logic b, input string name,
                         input int exp_count, input int exp_dir);
    int seen_at = 0;
    int width = 0;
    ph_a = a; ph_b = b;
    for (int i = 1; i <= LAT + 2; i++) begin
      tick(1);
      if (step) begin
        width++;
        if (seen_at == 0) seen_at = i;
      end
    end
    chk({name, "_lat"}, seen_at, LAT);
    chk({name, "_width"}, width, 1);
    chk({name, "_count"}, count, exp_count);
    chk({name, "_dir"}, dir, exp_dir);
  endtask

  logic [1:0] seq [4];
  int p0;

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;

    // Release with both phases high: no motion, no error.
    ph_a = 1; ph_b = 1;
    #1 reset = 1;
    tick(3);
    chk("rst_count", count, 0);
    chk("rst_step", step, 0);
    chk("rst_err", err, 0);
    p0 = pulses;
    reset = 0;
    tick(10);
    chk("idle11_count", count, 0);
    chk("idle11_err", err, 0);
    chk("idle11_steps", pulses - p0, 0);

    // Four up steps.
    reset_dut(0, 0);
    p0 = pulses;
    move_to(1, 0, "up1", 1, 1); tick(3);
    move_to(1, 1, "up2", 2, 1); tick(3);
    move_to(0, 1, "up3", 3, 1); tick(3);
    move_to(0, 0, "up4", 4, 1); tick(3);
    chk("up_pulses", pulses - p0, 4);

    // Down wrap, then preset colliding with an up step, then up wrap.
    reset_dut(0, 0);
    move_to(0, 1, "dn_wrap", 31, 0);
    ph_a = 0; ph_b = 0;
    tick(LAT - 1);
    preset = 1;
    tick(1);
    preset = 0;
    chk("preset_step", step, 0);
    chk("preset_count", count, 31);
    chk("preset_dir", dir, 0);
    tick(3);
    move_to(1, 0, "up_wrap", 0, 1);

    // Illegal jumps and err_clr priority.
    reset_dut(0, 0);
    ph_a = 1; ph_b = 1;
    tick(LAT + 2);
    chk("ill_err", err, 1);
    chk("ill_count", count, 0);
    move_to(1, 0, "ill_dn", 31, 0);
    ph_a = 0; ph_b = 1;
    tick(LAT - 1);
    err_clr = 1;
    tick(1);
    err_clr = 0;
    chk("setwins_err", err, 1);
    chk("setwins_count", count, 31);
    tick(2);
    err_clr = 1;
    tick(1);
    err_clr = 0;
    chk("clr_err", err, 0);

    // Reset in flight discards the pending edge.
    reset_dut(0, 0);
    p0 = pulses;
    ph_a = 1;
    tick(1);
    reset = 1;
    tick(2);
    reset = 0;
    tick(10);
    chk("inflight_count", count, 0);
    chk("inflight_steps", pulses - p0, 0);
    chk("inflight_err", err, 0);

`ifdef QDEC_FILTER_EN
    reset_dut(0, 0);
    p0 = pulses;
    ph_a = 1;
    tick(2);
    ph_a = 0;
    tick(12);
    chk("glitch_steps", pulses - p0, 0);
    chk("glitch_err", err, 0);
    move_to(1, 0, "filt_up", 1, 1);
`endif

    // Randomized walk checked by the model every cycle.
    reset_dut(0, 0);
    for (int it = 0; it < 600; it++) begin
      int r;
      int p;
      logic [1:0] nx;
      r = $urandom_range(0, 99);
      p = pos({ph_a, ph_b});
      if (r < 40) begin
        nx = seq[(p + 1) % 4]; ph_a = nx[1]; ph_b = nx[0];
      end else if (r < 80) begin
        nx = seq[(p + 3) % 4]; ph_a = nx[1]; ph_b = nx[0];
      end else if (r < 86) begin
        nx = seq[(p + 2) % 4]; ph_a = nx[1]; ph_b = nx[0];
      end else if (r < 92) begin
        ph_a = ~ph_a;
        tick($urandom_range(1, 2));
        ph_a = ~ph_a;
      end else if (r < 95) begin
        reset = 1;
        tick(1);
        reset = 0;
      end
      preset  = ($urandom_range(0, 19) == 0);
      err_clr = ($urandom_range(0, 9) == 0);
      tick($urandom_range(1, 8));
    end
    preset = 0;
    err_clr = 0;
    tick(LAT + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
